// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg: address map, STATUS layout and decode regions for dmem_mmio_responder
package dmem_mmio_pkg;
    localparam logic [11:0] ADDR_TXDATA = 12'hFFC;
    localparam logic [11:0] ADDR_STATUS = 12'hFFD;
    localparam logic [11:0] ADDR_TIMER  = 12'hFFE;
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_BERR    = 3;
    localparam int ST_OCC_LSB = 8;
    localparam int ST_OCC_W   = 8;
    typedef enum logic [2:0] {REG_RAM, REG_TX, REG_ST, REG_TM, REG_BAD} region_e;
endpackage

// File: rtl/mmio_tx_fifo.sv
// mmio_tx_fifo: sync FIFO; ports clock/reset, push/wdata, pop, full/empty/count, head (holds last popped byte when empty)
module mmio_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  last_q, last_d;
    logic          do_push, do_pop;

    assign empty = cnt_q == '0;
    assign full  = cnt_q == CW'(DEPTH);
    assign count = cnt_q;
    assign head  = empty ? last_q : mem[rd_q];

    // a push into a full FIFO is only accepted when the same edge frees the head slot
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rd_d    = rd_q + AW'(do_pop);
        wr_d    = wr_q + AW'(do_push);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        last_d  = do_pop ? mem[rd_q] : last_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_q] <= wdata;
    end
endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: dmem port responder (RAM + TX FIFO/STATUS MMIO); ports clock/reset, address_dmem/data/wren -> q_dmem, tx_data/tx_valid/tx_ready, bus_err; DMEM_MMIO_TIMER_EN adds timer at 0xFFE
module dmem_mmio_responder
    import dmem_mmio_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_dmem,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q_dmem,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  bus_err
);
    localparam int RW = $clog2(RAM_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];
    region_e               region;
    logic                  full, empty, push, pop, st_wr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] status_word, q_dmem_q, q_dmem_d;
    logic                  ovf_q, ovf_d, berr_q, berr_d;
`ifdef DMEM_MMIO_TIMER_EN
    logic [31:0]           timer_q, timer_d;
`endif

    mmio_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (push),
        .wdata(data[7:0]),
        .pop  (pop),
        .full (full),
        .empty(empty),
        .count(count),
        .head (tx_data)
    );

    assign tx_valid = !empty;
    assign q_dmem   = q_dmem_q;
    assign bus_err  = berr_q;

    // every cycle is an access: an idle processor must park on a mapped address
    always_comb begin
        region = address_dmem < ADDR_WIDTH'(RAM_DEPTH)       ? REG_RAM :
                 address_dmem == ADDR_WIDTH'(ADDR_TXDATA)    ? REG_TX  :
                 address_dmem == ADDR_WIDTH'(ADDR_STATUS)    ? REG_ST  :
`ifdef DMEM_MMIO_TIMER_EN
                 address_dmem == ADDR_WIDTH'(ADDR_TIMER)     ? REG_TM  :
`endif
                 REG_BAD;
        push  = wren && region == REG_TX;
        pop   = tx_valid && tx_ready;
        st_wr = wren && region == REG_ST;
        status_word = '0;
        status_word[ST_EMPTY] = empty;
        status_word[ST_FULL]  = full;
        status_word[ST_OVF]   = ovf_q;
        status_word[ST_BERR]  = berr_q;
        status_word[ST_OCC_LSB +: ST_OCC_W] = ST_OCC_W'(count);
        // sticky sets take priority over same-cycle W1C clears
        ovf_d  = (push && full && !pop) || (ovf_q && !(st_wr && data[ST_OVF]));
        berr_d = (region == REG_BAD) || (berr_q && !(st_wr && data[ST_BERR]));
        q_dmem_d = region == REG_RAM ? ram[address_dmem[RW-1:0]] :
                   region == REG_ST  ? status_word :
`ifdef DMEM_MMIO_TIMER_EN
                   region == REG_TM  ? DATA_WIDTH'(timer_q) :
`endif
                   '0;
`ifdef DMEM_MMIO_TIMER_EN
        timer_d = (wren && region == REG_TM) ? 32'(data) : timer_q + 32'd1;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_dmem_q <= '0;
            ovf_q    <= 1'b0;
            berr_q   <= 1'b0;
`ifdef DMEM_MMIO_TIMER_EN
            timer_q  <= '0;
`endif
        end else begin
            q_dmem_q <= q_dmem_d;
            ovf_q    <= ovf_d;
            berr_q   <= berr_d;
`ifdef DMEM_MMIO_TIMER_EN
            timer_q  <= timer_d;
`endif
        end
    end

    // read-first: q_dmem_d samples the old word before this write lands
    always_ff @(posedge clock) begin
        if (wren && region == REG_RAM) ram[address_dmem[RW-1:0]] <= data;
    end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed + random checks of dmem_mmio_responder against a queue-based model
module tb_dmem_mmio_responder;
    logic        clock, reset, wren, tx_ready, tx_valid, bus_err;
    logic [11:0] address_dmem;
    logic [31:0] data, q_dmem;
    logic [7:0]  tx_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram_m [int];
    logic [7:0]  fq [$];
    logic [7:0]  last_m;
    logic        ovf_m, berr_m;
    logic [31:0] timer_m;

    dmem_mmio_responder dut (
        .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
        .q_dmem(q_dmem), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .bus_err(bus_err)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // 0 RAM, 1 TXDATA, 2 STATUS, 3 TIMER, 4 unmapped
    function automatic int region(input logic [11:0] a);
        if (a < 12'd1024) return 0;
        if (a == 12'hFFC) return 1;
        if (a == 12'hFFD) return 2;
`ifdef DMEM_MMIO_TIMER_EN
        if (a == 12'hFFE) return 3;
`endif
        return 4;
    endfunction

    task automatic model_reset();
        fq.delete();
        last_m = 8'h00;
        ovf_m = 0;
        berr_m = 0;
        timer_m = 0;
    endtask

    task automatic cyc(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r);
        int rg, sz;
        logic known, pop, ovf_set;
        logic [31:0] exp_q;
        address_dmem = a; data = d; wren = w; tx_ready = r;
        rg = region(a);
        sz = fq.size();
        known = 1;
        exp_q = 0;
        if (rg == 0) begin
            known = ram_m.exists(int'(a));
            exp_q = known ? ram_m[int'(a)] : 32'h0;
        end else if (rg == 2) begin
            exp_q = (32'(sz) << 8) | {28'h0, berr_m, ovf_m, sz == 4, sz == 0};
        end else if (rg == 3) begin
            exp_q = timer_m;
        end
        @(posedge clock);
        #1;
        pop = sz > 0 && r;
        ovf_set = 0;
        if (pop) last_m = fq.pop_front();
        if (w && rg == 1) begin
            if (sz == 4 && !pop) ovf_set = 1;
            else fq.push_back(d[7:0]);
        end
        ovf_m  = ovf_set ? 1'b1 : (w && rg == 2 && d[2]) ? 1'b0 : ovf_m;
        berr_m = (rg == 4) ? 1'b1 : (w && rg == 2 && d[3]) ? 1'b0 : berr_m;
        timer_m = (w && rg == 3) ? d : timer_m + 1;
        if (w && rg == 0) ram_m[int'(a)] = d;
        if (known) check("q_dmem", q_dmem, exp_q);
        check("tx_valid", 32'(tx_valid), 32'(fq.size() > 0));
        check("tx_data", 32'(tx_data), 32'(fq.size() > 0 ? fq[0] : last_m));
        check("bus_err", 32'(bus_err), 32'(berr_m));
    endtask

    task automatic status_is(input logic [31:0] exp);
        cyc(12'hFFD, 0, 0, 0);
        check("status", q_dmem, exp);
    endtask

    initial begin
        reset = 1; address_dmem = 0; data = 0; wren = 0; tx_ready = 0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_q", q_dmem, 0);
        check("rst_valid", 32'(tx_valid), 0);
        check("rst_txdata", 32'(tx_data), 0);
        check("rst_berr", 32'(bus_err), 0);
        reset = 0;
        model_reset();
        cyc(0, 0, 1, 0);
        // RAM write/read and read-first
        cyc(12'h010, 32'h12345678, 1, 0);
        cyc(12'h010, 0, 0, 0);
        check("ram_rd", q_dmem, 32'h12345678);
        cyc(12'h010, 32'hAAAA0000, 1, 0);
        check("ram_rdfirst", q_dmem, 32'h12345678);
        cyc(12'h010, 0, 0, 0);
        check("ram_new", q_dmem, 32'hAAAA0000);
        // fill, overflow, drain, W1C
        for (int i = 0; i < 4; i++) cyc(12'hFFC, 32'h41 + i, 1, 0);
        status_is(32'h0402);
        cyc(12'hFFC, 32'h45, 1, 0);
        status_is(32'h0406);
        for (int i = 0; i < 4; i++) begin
            check("drain_byte", 32'(tx_data), 32'h41 + i);
            cyc(0, 0, 0, 1);
        end
        check("drain_done", 32'(tx_valid), 0);
        status_is(32'h0005);
        cyc(12'hFFD, 32'h4, 1, 0);
        status_is(32'h0001);
        // push while full with simultaneous pop
        for (int i = 0; i < 4; i++) cyc(12'hFFC, 32'h1 + i, 1, 0);
        cyc(12'hFFC, 32'h55, 1, 1);
        status_is(32'h0402);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        check("fifth_byte", 32'(tx_data), 32'h55);
        cyc(0, 0, 0, 1);
        // unmapped access and W1C bus_err
        cyc(12'hF00, 0, 0, 0);
        check("unmapped_q", q_dmem, 0);
        check("unmapped_err", 32'(bus_err), 1);
        cyc(12'hFFD, 32'h8, 1, 0);
        check("berr_clr", 32'(bus_err), 0);
        // timer wrap (or unmapped when timer disabled)
        cyc(12'hFFE, 32'hFFFFFFFE, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(12'hFFE, 0, 0, 0);
        cyc(12'hFFD, 32'hC, 1, 0);
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [11:0] a;
            int sel;
            sel = $urandom_range(0, 9);
            a = sel < 4 ? 12'($urandom_range(0, 31)) :
                sel < 6 ? 12'hFFC : sel < 8 ? 12'hFFD : sel < 9 ? 12'hFFE : 12'($urandom_range(1024, 4091));
            cyc(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        // async reset mid-drain with three entries
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(12'hFFC, 32'h60 + i, 1, 0);
        check("pre_rst_valid", 32'(tx_valid), 1);
        tx_ready = 1;
        #2;
        reset = 1;
        #1;
        check("async_valid", 32'(tx_valid), 0);
        check("async_txdata", 32'(tx_data), 0);
        check("async_q", q_dmem, 0);
        #1;
        reset = 0;
        model_reset();
        status_is(32'h0001);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
